// File: rtl/y86_pkg.sv
// Shared constants for the SEQ Y86-64 commit stage: instruction codes,
// status codes, register specifiers and the status-priority function.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   typedef enum logic {ST_RUN, ST_STOP} wb_state_t;

   // Fetch faults outrank decode faults, which outrank memory faults and halt.
   function automatic logic [2:0] status_of(input logic       imem_error,
                                            input logic       instr_valid,
                                            input logic       dmem_error,
                                            input logic [3:0] icode);
      if (imem_error)        return SADR;
      else if (!instr_valid) return SINS;
      else if (dmem_error)   return SADR;
      else if (icode == IHALT) return SHLT;
      else                   return SAOK;
   endfunction

endpackage

// File: rtl/y86_writeback_pc_if.sv
// Bundle of per-instruction inputs and architectural-state outputs of the
// commit stage; the slave side is the commit stage itself.
interface y86_writeback_pc_if;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        cnd;
   logic [63:0] valE;
   logic [63:0] valM;
   logic [63:0] valC;
   logic [63:0] valP;
   logic        imem_error;
   logic        instr_valid;
   logic        dmem_error;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] valA_rd;
   logic [63:0] valB_rd;
   logic [63:0] pc;
   logic [2:0]  stat;
   logic        halted;
   logic [63:0] retired;

   modport master (
      output icode, rA, rB, cnd, valE, valM, valC, valP,
             imem_error, instr_valid, dmem_error, srcA, srcB,
      input  valA_rd, valB_rd, pc, stat, halted, retired
   );

   modport slave (
      input  icode, rA, rB, cnd, valE, valM, valC, valP,
             imem_error, instr_valid, dmem_error, srcA, srcB,
      output valA_rd, valB_rd, pc, stat, halted, retired
   );
endinterface

// File: rtl/y86_regfile.sv
// 15x64 Y86-64 register file: two combinational read ports, two write ports
// (E and M) where M wins on a shared destination; specifier F is "no register".
module y86_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_RSP = 64'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] rd_a,
   output logic [63:0] rd_b,
   input  logic        we,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m
);

   logic [63:0] w_regs [0:14];

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_reg
         logic [63:0] r_q;

         always_ff @(posedge clk) begin
            if (reset)
               r_q <= (4'(gi) == RRSP) ? RESET_RSP : 64'd0;
            else if (we && dst_m == 4'(gi))
               r_q <= val_m;
            else if (we && dst_e == 4'(gi))
               r_q <= val_e;
         end

         assign w_regs[gi] = r_q;
      end
   endgenerate

   // Reads see the pre-edge contents; there is deliberately no write bypass.
   assign rd_a = (src_a == RNONE) ? 64'd0 : w_regs[src_a];
   assign rd_b = (src_b == RNONE) ? 64'd0 : w_regs[src_b];

endmodule

// File: rtl/y86_writeback_pc.sv
// SEQ Y86-64 commit stage: owns register file, PC, status and retired count;
// commits one instruction per edge until a non-AOK status freezes the machine.
module y86_writeback_pc
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter logic [63:0] RESET_RSP = 64'd0
) (
   input  logic               clk,
   input  logic               reset,
   y86_writeback_pc_if.slave  wb
);

   wb_state_t   r_state, w_state_next;
   logic [63:0] r_pc, w_pc_next;
   logic [2:0]  r_stat, w_stat_next;
   logic [63:0] r_retired, w_retired_next;

   logic [3:0]  w_dst_e;
   logic [3:0]  w_dst_m;
   logic [63:0] w_new_pc;
   logic [2:0]  w_status;
   logic        w_commit;

   always_comb begin
      w_dst_e = RNONE;
      w_dst_m = RNONE;
      w_new_pc = wb.valP;
      case (wb.icode)
         IRRMOVQ:                      w_dst_e = wb.cnd ? wb.rB : RNONE;
         IIRMOVQ, IOPQ:                w_dst_e = wb.rB;
         ICALL, IRET, IPUSHQ, IPOPQ:   w_dst_e = RRSP;
         default:                      w_dst_e = RNONE;
      endcase
      if (wb.icode == IMRMOVQ || wb.icode == IPOPQ)
         w_dst_m = wb.rA;
      if (wb.icode == ICALL || (wb.icode == IJXX && wb.cnd))
         w_new_pc = wb.valC;
      else if (wb.icode == IRET)
         w_new_pc = wb.valM;
   end

   assign w_status = status_of(wb.imem_error, wb.instr_valid, wb.dmem_error, wb.icode);
   assign w_commit = (r_state == ST_RUN) && (w_status == SAOK);

   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_stat_next    = r_stat;
      w_retired_next = r_retired;
      if (r_state == ST_RUN) begin
         if (w_status == SAOK) begin
            w_pc_next      = w_new_pc;
            w_retired_next = r_retired + 64'd1;
         end else begin
            // pc keeps pointing at the faulting or halting instruction
            w_stat_next  = w_status;
            w_state_next = ST_STOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_pc      <= RESET_PC;
         r_stat    <= SAOK;
         r_retired <= 64'd0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_stat    <= w_stat_next;
         r_retired <= w_retired_next;
      end
   end

   y86_regfile #(
      .RESET_RSP (RESET_RSP)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .src_a (wb.srcA),
      .src_b (wb.srcB),
      .rd_a  (wb.valA_rd),
      .rd_b  (wb.valB_rd),
      .we    (w_commit),
      .dst_e (w_dst_e),
      .val_e (wb.valE),
      .dst_m (w_dst_m),
      .val_m (wb.valM)
   );

   assign wb.pc      = r_pc;
   assign wb.stat    = r_stat;
   assign wb.halted  = (r_stat != SAOK);
   assign wb.retired = r_retired;

endmodule
